// File: rtl/lcd_screen_fetcher.sv
// Streams a 2x16 LCD screen, one character at a time, from the RAM controller's
// shared read port. The screen is a menu title/option pair or a 32-byte RAM dump.
module lcd_screen_fetcher #(
    parameter int LINE_LEN = 16,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              refresh_req,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] title_sel,
    input  logic [ADDR_W-1:0] option_sel,
    output logic [1:0]        ram_sel,
    output logic [ADDR_W-1:0] menu_sel,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] lcd_pos,
    output logic [7:0]        lcd_char,
    output logic              lcd_valid,
    input  logic              lcd_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LEN  = ADDR_W'(LINE_LEN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2 * LINE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_LATCH,
        S_SEND
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_title;
    logic [ADDR_W-1:0] r_option;
    logic [ADDR_W-1:0] r_pos;
    logic              r_pending;

    logic              w_start;
    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [1:0]        w_mode;
    logic [ADDR_W-1:0] w_title;
    logic [ADDR_W-1:0] w_option;
    logic [ADDR_W-1:0] w_pos;
    logic [1:0]        w_sel;
    logic [ADDR_W-1:0] w_menu;
    logic [ADDR_W-1:0] w_addr;

    // Non-printable bytes (and anything unknown) show as a blank.
    function automatic logic [7:0] f_filter(input logic [7:0] d);
        if (d >= 8'h20 && d <= 8'h7E)
            return d;
        return 8'h20;
    endfunction

    assign w_start  = (r_state == S_IDLE) && (refresh_req || r_pending);
    assign w_accept = (r_state == S_SEND) && lcd_ready;
    assign w_last   = (r_pos == LAST);
    assign w_load   = w_start || (w_accept && !w_last);
    assign w_mode   = w_start ? ((mode == 2'd3) ? 2'd0 : mode) : r_mode;
    assign w_title  = w_start ? title_sel : r_title;
    assign w_option = w_start ? option_sel : r_option;
    assign w_pos    = w_start ? '0 : r_pos + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = S_SETUP;
            S_SETUP: w_next = S_LATCH;
            S_LATCH: w_next = S_SEND;
            S_SEND:  if (w_accept) w_next = w_last ? S_IDLE : S_SETUP;
            default: w_next = S_IDLE;
        endcase
    end

    // Port values for the position about to be fetched.
    always_comb begin
        w_sel  = w_mode;
        w_menu = menu_sel;
        w_addr = w_pos;
        if (w_mode == 2'd0) begin
            if (w_pos < LEN) begin
                w_menu = w_title;
            end else begin
                w_menu = w_option;
                w_addr = w_pos - LEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= '0;
            r_title   <= '0;
            r_option  <= '0;
            r_pos     <= '0;
            r_pending <= 1'b0;
            ram_sel   <= '0;
            menu_sel  <= '0;
            ram_addr  <= '0;
            lcd_pos   <= '0;
            lcd_char  <= 8'h20;
            lcd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_start)
                r_pending <= 1'b0;
            else if (refresh_req)
                r_pending <= 1'b1;
            if (w_start) begin
                r_mode   <= w_mode;
                r_title  <= w_title;
                r_option <= w_option;
                busy     <= 1'b1;
            end
            if (w_load) begin
                r_pos    <= w_pos;
                ram_sel  <= w_sel;
                menu_sel <= w_menu;
                ram_addr <= w_addr;
            end
            if (r_state == S_LATCH) begin
                lcd_char  <= f_filter(ram_dout);
                lcd_pos   <= r_pos;
                lcd_valid <= 1'b1;
            end
            if (w_accept) begin
                lcd_valid <= 1'b0;
                if (w_last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_screen_fetcher.sv
// Directed bench for lcd_screen_fetcher with a behavioural RAM controller
// (menu ROM, remote RAM, local RAM, 1-cycle registered read port).
module tb_lcd_screen_fetcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refresh_req = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [4:0] title_sel = 5'd0;
    logic [4:0] option_sel = 5'd0;
    logic [1:0] ram_sel;
    logic [4:0] menu_sel;
    logic [4:0] ram_addr;
    logic [7:0] ram_dout;
    logic [4:0] lcd_pos;
    logic [7:0] lcd_char;
    logic       lcd_valid;
    logic       lcd_ready = 1'b0;
    logic       busy;
    logic       done;

    lcd_screen_fetcher #(.LINE_LEN(16), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .refresh_req(refresh_req),
        .mode(mode), .title_sel(title_sel), .option_sel(option_sel),
        .ram_sel(ram_sel), .menu_sel(menu_sel), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .lcd_pos(lcd_pos), .lcd_char(lcd_char),
        .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] menu_rom [0:31][0:15];
    logic [7:0] rram [0:31];
    logic [7:0] lram [0:31];

    always @(posedge clk) begin
        case (ram_sel)
            2'd0:    ram_dout <= menu_rom[menu_sel][ram_addr[3:0]];
            2'd1:    ram_dout <= rram[ram_addr];
            2'd2:    ram_dout <= lram[ram_addr];
            default: ram_dout <= 8'hFF;
        endcase
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string row_str(input int r);
        case (r)
            0:       return "MAIN MENU MASTER";
            2:       return "Display Remote  ";
            8:       return "ARE YOU SURE?   ";
            default: return "                ";
        endcase
    endfunction

    function automatic logic [7:0] exp_ch(input int md, input int t, input int o, input int p);
        string s;
        if (md == 2)
            return (p == 5 || p == 20) ? 8'h20 : 8'(8'h41 + p);
        if (md == 1)
            return 8'(8'h30 + p);
        s = (p < 16) ? row_str(t) : row_str(o);
        return s[p % 16];
    endfunction

    logic [7:0]  a_char [0:63];
    logic [4:0]  a_pos  [0:63];
    logic [1:0]  a_sel  [0:63];
    logic [4:0]  a_addr [0:63];
    int          a_n, e0, done_cyc, bcnt, last_acc;
    logic [31:0] lfsr = 32'hACE1_2345;
    bit          ab;

    task automatic run_screen(input bit go, input bit rnd, input bit extra,
                              input int rst_at, output bit aborted);
        bit         hold = 0;
        bit         seen = 0;
        logic [7:0] hc = 8'h0;
        logic [4:0] hp = 5'h0;
        a_n = 0; bcnt = 0; done_cyc = -1; last_acc = -1; aborted = 0;
        if (go) begin
            @(negedge clk);
            refresh_req = 1'b1;
        end
        e0 = cyc + 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            refresh_req = (extra && (n == 10 || n == 40 || n == 70)) ||
                          (rst_at >= 0 && n == 10);
            if (extra && n == 50)
                title_sel = 5'd8;
            if (rnd) begin
                lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
                lcd_ready = lfsr[0];
            end
            if (hold) begin
                chk("hold_valid", 32'(lcd_valid), 32'd1);
                chk("hold_char", 32'(lcd_char), 32'(hc));
                chk("hold_pos", 32'(lcd_pos), 32'(hp));
            end
            if (busy)
                bcnt++;
            if (done) begin
                done_cyc = cyc;
                seen = 1;
                break;
            end
            if (rst_at >= 0 && lcd_valid && lcd_pos == 5'(rst_at)) begin
                rst_n = 1'b0;
                aborted = 1;
                break;
            end
            if (lcd_valid && lcd_ready && a_n < 64) begin
                a_char[a_n] = lcd_char;
                a_pos[a_n]  = lcd_pos;
                a_sel[a_n]  = ram_sel;
                a_addr[a_n] = ram_addr;
                last_acc = cyc;
                a_n++;
            end
            hold = lcd_valid && !lcd_ready;
            hc = lcd_char;
            hp = lcd_pos;
        end
        refresh_req = 1'b0;
        if (!aborted)
            chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_screen(input int md, input int t, input int o);
        int n;
        chk("char_count", 32'(a_n), 32'd32);
        n = (a_n < 32) ? a_n : 32;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("pos[%0d]", i), 32'(a_pos[i]), 32'(i));
            chk($sformatf("char[%0d]", i), 32'(a_char[i]), 32'(exp_ch(md, t, o, i)));
            chk($sformatf("sel[%0d]", i), 32'(a_sel[i]), (md == 3) ? 32'd0 : 32'(md));
            chk($sformatf("addr[%0d]", i), 32'(a_addr[i]),
                (md == 1 || md == 2) ? 32'(i) : 32'(i % 16));
        end
        chk("done_after_last", 32'(done_cyc), 32'(last_acc + 1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(lcd_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_char"}, 32'(lcd_char), 32'h20);
        chk({tag, "_pos"}, 32'(lcd_pos), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_sel"}, 32'(ram_sel), 32'd0);
        chk({tag, "_msel"}, 32'(menu_sel), 32'd0);
    endtask

    initial begin
        int d1;
        int quiet;
        string s;
        for (int r = 0; r < 32; r++) begin
            s = row_str(r);
            for (int c = 0; c < 16; c++)
                menu_rom[r][c] = s[c];
        end
        for (int i = 0; i < 32; i++) begin
            rram[i] = 8'(8'h30 + i);
            lram[i] = 8'(8'h41 + i);
        end
        lram[5]  = 8'h07;
        lram[20] = 8'hFF;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Menu screen, ready always high: exact timing.
        mode = 2'd0; title_sel = 5'd0; option_sel = 5'd2; lcd_ready = 1'b1;
        run_screen(1, 0, 0, -1, ab);
        check_screen(0, 0, 2);
        chk("t1_done_cyc", 32'(done_cyc), 32'(e0 + 96));
        chk("t1_busy_cycles", 32'(bcnt), 32'd96);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Local RAM dump with non-printable bytes.
        mode = 2'd2;
        run_screen(1, 0, 0, -1, ab);
        check_screen(2, 0, 2);
        chk("t2_done_cyc", 32'(done_cyc), 32'(e0 + 96));

        // Remote RAM dump with random backpressure.
        mode = 2'd1;
        run_screen(1, 1, 0, -1, ab);
        check_screen(1, 0, 2);
        lcd_ready = 1'b1;

        // Requests during a screen collapse into one follow-on screen.
        mode = 2'd0; title_sel = 5'd0; option_sel = 5'd2;
        run_screen(1, 0, 1, -1, ab);
        check_screen(0, 0, 2);
        d1 = done_cyc;
        run_screen(0, 0, 0, -1, ab);
        check_screen(0, 8, 2);
        chk("t4_follow_done", 32'(done_cyc), 32'(d1 + 97));
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done || lcd_valid)
                quiet++;
        end
        chk("t4_single_follow", 32'(quiet), 32'd0);

        // Reset mid-SEND at character 10, with a request pending.
        run_screen(1, 0, 0, 10, ab);
        chk("t5_aborted", 32'(ab), 32'd1);
        #1;
        check_reset_vals("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done || lcd_valid)
                quiet++;
        end
        chk("t5_no_activity", 32'(quiet), 32'd0);
        run_screen(1, 0, 0, -1, ab);
        check_screen(0, 8, 2);

        // Mode 3 behaves as a menu screen.
        mode = 2'd3; title_sel = 5'd0; option_sel = 5'd2;
        run_screen(1, 0, 0, -1, ab);
        check_screen(3, 0, 2);
        chk("t6_done_cyc", 32'(done_cyc), 32'(e0 + 96));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_screen_fetcher.md
# lcd_screen_fetcher

Sequences character reads out of the I2C RAM controller's shared multi-RAM read port and streams them, one character at a time, to the LCD character writer. It renders a full 2x16 screen per refresh request. The screen is either a menu screen (title row plus option row from the menu ROM) or a dump of the 32-byte remote or local RAM. It drives the RAM controller's select, menu-select and address inputs, consumes its registered data output, and sits between the menu controller (which requests refreshes) and the LCD driver (which accepts characters through a valid/ready handshake).

## Interface
- LINE_LEN, 16, characters per LCD line; a screen is 2*LINE_LEN = 32 characters
- ADDR_W, 5, RAM/ROM address width and LCD position width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- refresh_req  in  1  request to redraw the screen (level or pulse)
- mode  in  2  0 = menu screen, 1 = remote RAM dump, 2 = local RAM dump, 3 = treated as 0
- title_sel  in  5  menu ROM row for line 0 (mode 0)
- option_sel  in  5  menu ROM row for line 1 (mode 0)
- ram_sel  out  2  RAM select to controller (0 menu, 1 remote, 2 local)
- menu_sel  out  5  menu ROM row select to controller
- ram_addr  out  5  address to controller multi-RAM port
- ram_dout  in  8  controller multi-RAM data out (registered, 1-cycle latency)
- lcd_pos  out  5  screen position of lcd_char; bit 4 = line, bits 3:0 = column
- lcd_char  out  8  character to display
- lcd_valid  out  1  lcd_char/lcd_pos valid
- lcd_ready  in  1  LCD writer accepts when lcd_valid && lcd_ready
- busy  out  1  refresh in progress
- done  out  1  one-cycle pulse: last character accepted

## Operation
- States: IDLE, SETUP, LATCH, SEND.
- IDLE: when refresh_req or pending is set, latch mode (3 is mapped to 0), title_sel and option_sel. Clear pending, set pos = 0 and busy = 1, load the port outputs for pos 0, go to SETUP.
- Port outputs for position p, mode 0:
  - p < 16: ram_sel = 0, menu_sel = title, ram_addr = p
  - p >= 16: ram_sel = 0, menu_sel = option, ram_addr = p - 16
- Port outputs for position p, mode 1/2: ram_sel = mode, ram_addr = p. menu_sel holds its last value.
- Port outputs hold stable from SETUP through SEND for each character.
- SETUP: the controller samples the address on this edge; go to LATCH.
- LATCH: lcd_char = filter(ram_dout), lcd_pos = pos, lcd_valid = 1; go to SEND.
- filter: a byte in 0x20..0x7E passes unchanged; any other byte, including X/uninitialised, becomes 0x20.
- SEND: hold lcd_valid, lcd_char and lcd_pos until lcd_ready. On acceptance, lcd_valid = 0, then:
  - pos == 31: busy = 0, done = 1 for one cycle, go to IDLE.
  - otherwise: pos = pos + 1 (5-bit, never wraps within a screen), load port outputs for the new pos, go to SETUP.
- refresh_req while busy sets pending; multiple requests collapse into one. Latched inputs are not updated mid-screen. Changes to mode or selects while busy are ignored.
- Reset mid-screen aborts immediately: no done pulse, pending cleared.

## Timing
- Reset values: ram_sel = 0, menu_sel = 0, ram_addr = 0, lcd_pos = 0, lcd_char = 0x20, lcd_valid = 0, busy = 0, done = 0, pending = 0, state IDLE.
- Edge e0: request accepted in IDLE; busy high after e0.
- Edge e0+2: character 0 presented (lcd_valid high).
- With lcd_ready held high:
  - character k is accepted at edge e0 + 3(k+1)
  - character 31 is accepted at edge e0 + 96
  - done is high and busy low for the cycle after e0 + 96
- Each lcd_ready-low cycle in SEND adds one cycle for that character.
- With pending set, the next screen is accepted at edge e0 + 97 (one IDLE cycle), so done and the new busy never overlap.
- done and the lcd_valid drop occur on the same edge.

## Test plan
- Reset, mode 0, title 0, option 2, refresh pulse, lcd_ready = 1:
  - 32 chars, pos 0..31; line 0 "MAIN MENU MASTER", line 1 "Display Remote  "
  - done at cycle 97, busy high for 96 cycles
- Mode 2, local RAM preloaded with 0x41+i, except byte 5 = 0x07 and byte 20 = 0xFF:
  - outputs 0x41+i; positions 5 and 20 emit 0x20
  - ram_sel = 2, ram_addr = pos
- lcd_ready toggled pseudo-randomly:
  - lcd_char/lcd_pos stable while valid && !ready; no character lost or duplicated
  - done one cycle after the 32nd acceptance
- refresh_req pulsed 3 times during a screen, with title changed to 8 mid-screen:
  - current screen unchanged, exactly one follow-on screen, started one cycle after done, showing "ARE YOU SURE?"
- rst_n asserted at character 10, mid-SEND:
  - all outputs immediately at reset values, no done
  - after release and a new request, the screen restarts at pos 0
- mode = 3: behaves exactly as mode 0, ram_sel = 0 throughout.
